// File: rtl/status_sequencer.sv
// status_sequencer: sequences the carry/zero status register. Stages {C,Z}
// from ALU results or the shadow stack, drives the register's active-low
// load strobe one cycle later, and evaluates branch conditions on the
// effective (forwarded) flags.
module status_sequencer #(
   parameter int DATA_WIDTH   = 16,
   parameter int SHADOW_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_carry,
   input  logic [1:0]            update_mask,
   input  logic                  save,
   input  logic                  restore,
   input  logic [2:0]            cond,
   input  logic                  cOut,
   input  logic                  zOut,
   output logic                  notLoad,
   output logic                  cIn,
   output logic                  zIn,
   output logic                  cond_true,
   output logic                  busy,
   output logic                  shadow_empty,
   output logic                  shadow_full,
   output logic [2:0]            err
);
   localparam int PW = $clog2(SHADOW_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {INIT, IDLE, LOAD} state_t;

   state_t          state, state_next;
   logic            stage_c, stage_z;
   logic            next_c, next_z;
   logic [1:0]      shadow [SHADOW_DEPTH];
   logic [CW-1:0]   depth;
   logic [PW-1:0]   top_idx;
   logic            eff_c, eff_z;
   logic            active, alu_zero;
   logic            do_restore, pop_ok, do_push, do_alu, accept;
   logic            save_restore_clash, restore_alu_clash;

   // Forwarding: while a load is in flight the staged value is the truth.
   assign eff_c = (state == LOAD) ? stage_c : cOut;
   assign eff_z = (state == LOAD) ? stage_z : zOut;

   assign active       = (state != INIT);
   assign alu_zero     = (alu_result == '0);
   assign shadow_empty = (depth == '0);
   assign shadow_full  = (depth == CW'(SHADOW_DEPTH));
   assign top_idx      = depth[PW-1:0] - PW'(1);

   // Simultaneous save+restore cancels both; a restore always beats the ALU.
   assign save_restore_clash = active & save & restore;
   assign do_restore         = active & restore & ~save;
   assign restore_alu_clash  = do_restore & alu_valid;
   assign pop_ok             = do_restore & ~shadow_empty;
   assign do_push            = active & save & ~restore & ~shadow_full;
   assign do_alu             = active & alu_valid & ~do_restore;
   assign accept             = pop_ok | do_alu;

   // Value to stage: popped entry, or masked merge of ALU flags into effective flags.
   always_comb begin
      next_c = update_mask[1] ? alu_carry : eff_c;
      next_z = update_mask[0] ? alu_zero  : eff_z;
      if (pop_ok) begin
         next_c = shadow[top_idx][1];
         next_z = shadow[top_idx][0];
      end
   end

   // Condition evaluation on the effective flags.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         3'd0: cond_true = 1'b1;
         3'd1: cond_true = eff_z;
         3'd2: cond_true = ~eff_z;
         3'd3: cond_true = eff_c;
         3'd4: cond_true = ~eff_c;
         3'd5: cond_true = eff_c & ~eff_z;
         3'd6: cond_true = ~eff_c | eff_z;
         default: cond_true = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= INIT;
      else       state <= state_next;
   end

   // Next state and register-side outputs.
   always_comb begin
      state_next = state;
      notLoad    = 1'b1;
      cIn        = stage_c;
      zIn        = stage_z;
      busy       = 1'b0;
      case (state)
         INIT: begin
            notLoad    = 1'b0;
            cIn        = 1'b0;
            zIn        = 1'b0;
            busy       = 1'b1;
            state_next = IDLE;
         end
         IDLE: state_next = accept ? LOAD : IDLE;
         LOAD: begin
            notLoad    = 1'b0;
            state_next = accept ? LOAD : IDLE;
         end
         default: state_next = INIT;
      endcase
   end

   // Staged flags, stack pointer and sticky errors.
   always_ff @(posedge clock) begin
      if (reset) begin
         stage_c <= 1'b0;
         stage_z <= 1'b0;
         depth   <= '0;
         err     <= '0;
      end else begin
         if (accept) begin
            stage_c <= next_c;
            stage_z <= next_z;
         end
         if (do_push)     depth <= depth + CW'(1);
         else if (pop_ok) depth <= depth - CW'(1);
         if (save_restore_clash | restore_alu_clash)          err[2] <= 1'b1;
         if (do_restore & shadow_empty)                       err[1] <= 1'b1;
         if (active & save & ~restore & shadow_full)          err[0] <= 1'b1;
      end
   end

   // Shadow stack storage; contents are don't-care beyond depth.
   always_ff @(posedge clock) begin
      if (do_push) shadow[depth[PW-1:0]] <= {eff_c, eff_z};
   end
endmodule
